// File: rtl/nes_joypad_pkg.sv
// Shared constants for the NES controller-port emulation: signatures,
// report lengths, button indices and the autofire gating helper.
package nes_joypad_pkg;

   localparam int unsigned CNT_W = 5;

   localparam logic [7:0] SIG_0 = 8'h08;
   localparam logic [7:0] SIG_1 = 8'h04;

   localparam logic [CNT_W-1:0] LIMIT_STD = 5'd8;
   localparam logic [CNT_W-1:0] LIMIT_FS  = 5'd24;

   localparam int unsigned BTN_A  = 0;
   localparam int unsigned BTN_B  = 1;
   localparam int unsigned SELECT = 2;
   localparam int unsigned START  = 3;
   localparam int unsigned UP     = 4;
   localparam int unsigned DOWN   = 5;
   localparam int unsigned LEFT   = 6;
   localparam int unsigned RIGHT  = 7;

   typedef enum logic {
      MODE_STD = 1'b0,
      MODE_FS  = 1'b1
   } mode_e;

   // Only A and B are gated; en[0] targets A, en[1] targets B.
   function automatic logic [7:0] gate_autofire(input logic [7:0] raw,
                                                input logic [1:0] en,
                                                input logic       phase);
      logic [7:0] eff;
      eff        = raw;
      eff[BTN_A] = raw[BTN_A] & (~en[0] | phase);
      eff[BTN_B] = raw[BTN_B] & (~en[1] | phase);
      return eff;
   endfunction

endpackage

// File: rtl/nes_joypad_chan.sv
// One controller port: latch on strobe, shift on read-clock falling edges,
// open-bus 1 once the report (8 or 24 bits) is exhausted.
module nes_joypad_chan
   import nes_joypad_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       strobe,
   input  logic       joy_clock,
   input  logic [7:0] pad_a,
   input  logic [7:0] pad_b,
   input  logic [7:0] sig,
   input  logic       fourscore,
   output logic       data
);

   logic [23:0]      sr, sr_n;
   logic [CNT_W-1:0] cnt, cnt_n, lim, lim_n;
   mode_e            mode, mode_n;
   logic             clk_q;
   logic             data_n;

   always_comb begin
      sr_n   = sr;
      cnt_n  = cnt;
      mode_n = mode;
      lim    = (mode == MODE_FS) ? LIMIT_FS : LIMIT_STD;
      if (strobe) begin
         mode_n = fourscore ? MODE_FS : MODE_STD;
         sr_n   = fourscore ? {sig, pad_b, pad_a} : {16'h0000, pad_a};
         cnt_n  = '0;
      end else if (!joy_clock && clk_q) begin
         sr_n = {1'b1, sr[23:1]};
         if (cnt < lim)
            cnt_n = cnt + 5'd1;
      end
      lim_n  = (mode_n == MODE_FS) ? LIMIT_FS : LIMIT_STD;
      // Output is computed from next state so data lands one cycle after the event.
      data_n = (cnt_n == lim_n) ? 1'b1 : sr_n[0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr    <= '0;
         cnt   <= '0;
         mode  <= MODE_STD;
         clk_q <= 1'b0;
         data  <= 1'b0;
      end else begin
         sr    <= sr_n;
         cnt   <= cnt_n;
         mode  <= mode_n;
         clk_q <= joy_clock;
         data  <= data_n;
      end
   end

endmodule

// File: rtl/nes_joypad_ports.sv
// NES $4016/$4017 controller ports with optional Four Score multitap,
// per-pad A/B autofire and UART loader button injection.
module nes_joypad_ports
   import nes_joypad_pkg::*;
#(
   parameter int unsigned NUM_PADS    = 2,
   parameter int unsigned FREQ        = 27_000_000,
   parameter int unsigned AUTOFIRE_HZ = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  joypad_strobe,
   input  logic [1:0]            joypad_clock,
   input  logic [8*NUM_PADS-1:0] pad_btn,
   input  logic [8*NUM_PADS-1:0] loader_btn,
   input  logic [2*NUM_PADS-1:0] autofire_en,
   input  logic                  fourscore_en,
   output logic [1:0]            joypad_data
);

   localparam int unsigned AF_DIV  = FREQ / (2 * AUTOFIRE_HZ);
   localparam int unsigned AF_W    = (AF_DIV > 1) ? $clog2(AF_DIV) : 1;
   localparam logic [AF_W-1:0] AF_LAST = AF_W'(AF_DIV - 1);

   logic [AF_W-1:0] af_cnt;
   logic            af_phase;
   logic [7:0]      eff [4];
   logic            fs;

   always_ff @(posedge clk) begin
      if (reset) begin
         af_cnt   <= '0;
         af_phase <= 1'b0;
      end else if (af_cnt == AF_LAST) begin
         af_cnt   <= '0;
         af_phase <= ~af_phase;
      end else begin
         af_cnt   <= af_cnt + 1'b1;
      end
   end

   // Pads beyond NUM_PADS read as released.
   always_comb begin
      for (int unsigned p = 0; p < 4; p++)
         eff[p] = '0;
      for (int unsigned p = 0; p < NUM_PADS; p++)
         eff[p] = gate_autofire(pad_btn[8*p +: 8] | loader_btn[8*p +: 8],
                                autofire_en[2*p +: 2], af_phase);
   end

   assign fs = fourscore_en && (NUM_PADS == 4);

   nes_joypad_chan u_chan0 (
      .clk       (clk),
      .reset     (reset),
      .strobe    (joypad_strobe),
      .joy_clock (joypad_clock[0]),
      .pad_a     (eff[0]),
      .pad_b     (eff[2]),
      .sig       (SIG_0),
      .fourscore (fs),
      .data      (joypad_data[0])
   );

   nes_joypad_chan u_chan1 (
      .clk       (clk),
      .reset     (reset),
      .strobe    (joypad_strobe),
      .joy_clock (joypad_clock[1]),
      .pad_a     (eff[1]),
      .pad_b     (eff[3]),
      .sig       (SIG_1),
      .fourscore (fs),
      .data      (joypad_data[1])
   );

endmodule

// File: doc/nes_joypad_ports.md
# nes_joypad_ports

Parametrised emulation of the two NES controller ports ($4016/$4017 serial readout) for the NES top level. It latches per-player button state on `joypad_strobe` and shifts it out on falling edges of `joypad_clock[1:0]`, replacing the inline 8-bit shifters. Additions over those shifters:
- up to four players with Four Score multitap framing;
- per-pad A/B autofire gating;
- correct open-bus "1" fill after the report is exhausted.

## Interface
Parameters:
- `NUM_PADS`, 2 — number of players; legal values are 2 or 4.
- `FREQ`, 27_000_000 — `clk` frequency in Hz.
- `AUTOFIRE_HZ`, 15 — autofire press rate in Hz; one full on/off period.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1 — system clock.
- `reset` in 1 — synchronous, active-high.
- `joypad_strobe` in 1 — CPU $4016 bit0 latch; level-sensitive.
- `joypad_clock` in 2 — per-port read clocks from the CPU; bit i belongs to port i.
- `pad_btn` in 8*NUM_PADS — pad p occupies bits [8p+7:8p], in NES order {R,L,D,U,Start,Select,B,A}, active-high.
- `loader_btn` in 8*NUM_PADS — UART-injected buttons, ORed with `pad_btn`.
- `autofire_en` in 2*NUM_PADS — pad p: bit 2p enables autofire on A, bit 2p+1 enables autofire on B.
- `fourscore_en` in 1 — enables multitap framing; ignored (treated as 0) when NUM_PADS=2.
- `joypad_data` out 2 — serial bit for port i (D0 line), active-high.

## Operation
- **Pad mapping**
  - Port 0 serves pads 0 and 2; port 1 serves pads 1 and 3.
  - Pads 2 and 3 are read only when `fourscore_en`=1.
- **Autofire**
  - A free-running counter counts to FREQ/(2*AUTOFIRE_HZ)-1, then wraps and toggles `af_phase`.
  - The counter and `af_phase` clear on reset.
  - Effective button = raw & (~en | af_phase), where raw = `pad_btn` | `loader_btn`. Gating applies to the A and B bits only.
- **Per-port channel**, with 24-bit shift register `sr`, bit counter `cnt` (0..24) and registered `clk_q`:
  - *Strobe* (`joypad_strobe`=1 in a cycle):
    - standard mode: sr <= {16'h0, effA}; cnt <= 0.
    - Four Score mode: sr <= {SIG_i, effB, effA}, where effA is the first pad on the port and effB the second.
    - The latch is repeated every cycle while strobe is high.
    - `joypad_data` follows bit 0 of the latched A button.
  - *Shift* (strobe=0, `joypad_clock[i]`=0, `clk_q[i]`=1, i.e. a falling edge):
    - sr <= {1'b1, sr[23:1]}.
    - cnt <= min(cnt+1, LIMIT), where LIMIT = 8 in standard mode and 24 in Four Score mode.
  - *Data output*: `joypad_data[i]` = cnt==LIMIT ? 1 : sr[0].
    - Standard mode: reads 9 onward return 1.
    - Four Score mode: reads 17..24 return the signature; reads 25 onward return 1.
  - Strobe has priority over a simultaneous shift edge. The edge is consumed, not deferred.
  - `clk_q` updates every cycle, including during strobe and reset.
- **Signatures** (LSB-first; they follow the 16 button bits):
  - SIG_0 = 8'h08, so only the 20th read of $4016 returns 1.
  - SIG_1 = 8'h04, so only the 19th read of $4017 returns 1.
- **Mode change**: toggling `fourscore_en` mid-report takes effect at the next strobe. The LIMIT in use is the one captured at strobe.

## Timing
- Reset values:
  - `sr`, `cnt`, `clk_q`, `af_phase` and the autofire counter all = 0.
  - `joypad_data` = 2'b00.
  - The captured mode = standard.
- `joypad_data` is registered:
  - 1-cycle latency from a strobe cycle or a falling-edge cycle to the new bit on the output.
- Edge detection uses `clk_q`, so a low level on `joypad_clock[i]` must be held at least 1 `clk` to register.
- Multiple falling edges separated by ≥2 cycles are each counted.
- Reset mid-report:
  - the channel returns to cnt=0, sr=0, output 0;
  - the next strobe starts a fresh report.
- Saturation: `cnt` never exceeds LIMIT, and further edges keep the output at 1.

## Structure
- Package `nes_joypad_pkg` holds:
  - SIG_0 and SIG_1;
  - LIMIT_STD=8 and LIMIT_FS=24;
  - button index constants BTN_A=0, BTN_B=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7;
  - `cnt` width = 5.
- Sub-module `nes_joypad_chan` implements one port: shift register, counter, edge detector and output register.
  - It takes the effective pad A/B bytes, the signature and the mode.
  - It is instantiated twice.
- The top holds the autofire divider and the button gating/OR logic.

## Test plan
- **Standard readout**: NUM_PADS=2, pad0=8'b1000_0001 (R and A pressed); strobe 1→0, then 10 falling edges on clock[0] → port-0 bits read 1,0,0,0,0,0,0,1,1,1.
- **Four Score**: NUM_PADS=4, `fourscore_en`=1, pad0=8'h01, pad2=8'h80; 26 reads on port 0 → 1 (A), 0×14, 1 (bit 15 = pad2 R), 0,0,0,1,0,0,0,0 (signature), then 1,1. Port 1 read concurrently with all pads 0 → 1 appears only at read 19, then 1s from read 25.
- **Strobe priority**: assert strobe in the same cycle as a clock[1] falling edge → cnt stays 0 and the output equals pad1 A.
- **Autofire**: FREQ=1000, AUTOFIRE_HZ=10, A held, `autofire_en` bit0=1; strobe every cycle → latched A alternates 0/1 every 50 cycles. With `autofire_en`=0, A stays 1.
- **Reset mid-report**: after 5 shifts, pulse `reset` for 1 cycle → `joypad_data`=0 and cnt=0; the next strobe restores normal readout.
- **Loader OR**: `pad_btn`=0, `loader_btn` pad1=8'h08 (Start) → the 4th port-1 read returns 1.
